// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode-to-player-command path.
package keycode_pkg;

  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {NONE = 2'd0, DIR = 2'd1, BOMB = 2'd2} cmd_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, HOLD = 2'd2, REPEAT = 2'd3} state_t;

  typedef struct packed {
    cmd_t cmd;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] kc);
    key_dec_t d;
    d.cmd = NONE;
    d.dir = DOWN;
    case (kc)
      KC_W:     begin d.cmd = DIR; d.dir = UP;    end
      KC_S:     begin d.cmd = DIR; d.dir = DOWN;  end
      KC_A:     begin d.cmd = DIR; d.dir = LEFT;  end
      KC_D:     begin d.cmd = DIR; d.dir = RIGHT; end
      KC_SPACE: d.cmd = BOMB;
      default:  d.cmd = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keycode_move_ctrl_if.sv
// Keycode PIO side and player-command side of keycode_move_ctrl.
interface keycode_move_ctrl_if;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;
  logic       bomb_drop;
  logic [1:0] facing;
  logic       moving;

  modport master (
    output keycode, frame_tick,
    input  move_up, move_down, move_left, move_right, bomb_drop, facing, moving
  );

  modport slave (
    input  keycode, frame_tick,
    output move_up, move_down, move_left, move_right, bomb_drop, facing, moving
  );
endinterface

// File: rtl/frame_counter.sv
// 8-bit saturating frame_tick counter with synchronous clear and terminal-count compare.
module frame_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] tc_val,
  output logic       tc
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (tick && (count_q != 8'hFF))
      count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/keycode_move_ctrl.sv
// HID keycode to Bomberman move/bomb pulses with hold auto-repeat.
// Optional bomb cooldown enabled by defining KEYCODE_BOMB_COOLDOWN_EN.
//
// state  | meaning
// IDLE   | no direction held
// FIRST  | one-cycle first-press move pulse, facing update
// HOLD   | waiting REPEAT_DELAY frames before auto-repeat
// REPEAT | pulsing every REPEAT_PERIOD frames while held
module keycode_move_ctrl
  import keycode_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12,
  parameter int REPEAT_PERIOD = 4,
  parameter int BOMB_COOLDOWN = 30
) (
  input  logic                 clk,
  input  logic                 reset_n,
  keycode_move_ctrl_if.slave   bus
);

  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255 ||
      BOMB_COOLDOWN < 1 || BOMB_COOLDOWN > 255) begin : g_bad_param
    $error("keycode_move_ctrl: timing parameters must lie in 1..255");
  end

  logic [7:0] key_q, key_prev_q;
  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       facing_q, facing_d;
  logic       bomb_q, bomb_d;

  key_dec_t   key_info;
  logic       key_chg;
  logic       move_pulse;
  logic       rpt_clr, rpt_tc;
  logic [7:0] rpt_tc_val;
  logic       bomb_edge, bomb_ok;

  assign key_info = decode_key(key_q);
  assign key_chg  = (key_info.cmd != DIR) || (key_info.dir != dir_q);

  assign rpt_tc_val = (state_q == REPEAT) ? 8'(REPEAT_PERIOD) : 8'(REPEAT_DELAY);

  frame_counter u_rpt_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (rpt_clr),
    .tick   (bus.frame_tick),
    .tc_val (rpt_tc_val),
    .tc     (rpt_tc)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    facing_d   = facing_q;
    move_pulse = 1'b0;
    rpt_clr    = 1'b1;
    case (state_q)
      IDLE: begin
        if (key_info.cmd == DIR) begin
          state_d = FIRST;
          dir_d   = key_info.dir;
        end
      end
      FIRST: begin
        move_pulse = 1'b1;
        facing_d   = dir_q;
        state_d    = HOLD;
      end
      HOLD, REPEAT: begin
        // A key change outranks both the terminal count and a same-cycle tick.
        if (key_chg) begin
          if (key_info.cmd == DIR) begin
            state_d = FIRST;
            dir_d   = key_info.dir;
          end else begin
            state_d = IDLE;
          end
        end else if (rpt_tc) begin
          move_pulse = 1'b1;
          state_d    = REPEAT;
        end else begin
          rpt_clr = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bomb_edge = (key_q == KC_SPACE) && (key_prev_q != KC_SPACE);

`ifdef KEYCODE_BOMB_COOLDOWN_EN
  logic cd_busy_q, cd_busy_d, cd_tc;

  frame_counter u_cd_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (bomb_d),
    .tick   (bus.frame_tick),
    .tc_val (8'(BOMB_COOLDOWN)),
    .tc     (cd_tc)
  );

  // Reaching the terminal count is the same frame the cooldown would hit zero.
  assign bomb_ok = !cd_busy_q || cd_tc;

  always_comb begin
    cd_busy_d = cd_busy_q;
    if (bomb_d)
      cd_busy_d = 1'b1;
    else if (cd_tc)
      cd_busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cd_busy_q <= 1'b0;
    else
      cd_busy_q <= cd_busy_d;
  end
`else
  assign bomb_ok = 1'b1;
`endif

  assign bomb_d = bomb_edge && bomb_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q      <= 8'h00;
      key_prev_q <= 8'h00;
      state_q    <= IDLE;
      dir_q      <= UP;
      facing_q   <= DOWN;
      bomb_q     <= 1'b0;
    end else begin
      key_q      <= bus.keycode;
      key_prev_q <= key_q;
      state_q    <= state_d;
      dir_q      <= dir_d;
      facing_q   <= facing_d;
      bomb_q     <= bomb_d;
    end
  end

  assign bus.move_up    = move_pulse && (dir_q == UP);
  assign bus.move_down  = move_pulse && (dir_q == DOWN);
  assign bus.move_left  = move_pulse && (dir_q == LEFT);
  assign bus.move_right = move_pulse && (dir_q == RIGHT);
  assign bus.bomb_drop  = bomb_q;
  assign bus.facing     = facing_q;
  assign bus.moving     = (state_q != IDLE);

endmodule
